// File: rtl/ws2812b_rx.sv
// WS2812B one-wire stream decoder.
// Recovers 24-bit pixel words, pixel positions and frame latches from the LED line.
module ws2812b_rx #(
    parameter int BIT_THRESH_CYC = 60,
    parameter int MIN_HIGH_CYC   = 10,
    parameter int MAX_HIGH_CYC   = 200,
    parameter int RESET_CYC      = 5000,
    parameter int IDX_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [23:0]      color,
    output logic             color_valid,
    output logic [IDX_W-1:0] pixel_index,
    output logic             frame_done,
    output logic             err
);

    localparam int CW = $clog2(RESET_CYC + 1);
    localparam logic [CW-1:0] RESET_V  = CW'(RESET_CYC);
    localparam logic [CW-1:0] MAX_V    = CW'(MAX_HIGH_CYC);
    localparam logic [CW-1:0] MIN_V    = CW'(MIN_HIGH_CYC);
    localparam logic [CW-1:0] THRESH_V = CW'(BIT_THRESH_CYC);
    localparam logic [CW-1:0] ONE_V    = CW'(1);

    typedef enum logic [1:0] {
        SYNC,
        LOW,
        HIGH
    } state_t;

    state_t           state;
    logic             din_m;
    logic             din_s;
    logic             din_q;
    logic [CW-1:0]    cnt;
    logic [23:0]      sr;
    logic [4:0]       bit_cnt;
    logic [IDX_W-1:0] pix_cnt;

    logic        lvl_edge;
    logic        rise;
    logic        fall;
    logic        reach_reset;
    logic        reach_max;
    logic        bit_val;
    logic [23:0] word;

    assign lvl_edge = din_s ^ din_q;
    assign rise     = lvl_edge & din_s;
    assign fall     = lvl_edge & ~din_s;
    // cnt lags the level by one cycle, so "reaching" a limit is cnt == limit-1
    assign reach_reset = ~lvl_edge & ~din_s & (cnt == RESET_V - ONE_V);
    assign reach_max   = ~lvl_edge & din_s & (cnt == MAX_V - ONE_V);
    assign bit_val     = (cnt >= THRESH_V);
    assign word        = {sr[22:0], bit_val};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_m <= 1'b0;
            din_s <= 1'b0;
            din_q <= 1'b0;
            cnt   <= '0;
        end else begin
            din_m <= din;
            din_s <= din_m;
            din_q <= din_s;
            if (lvl_edge) begin
                cnt <= ONE_V;
            end else if (cnt != RESET_V) begin
                cnt <= cnt + ONE_V;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SYNC;
            sr          <= '0;
            bit_cnt     <= '0;
            pix_cnt     <= '0;
            color       <= '0;
            color_valid <= 1'b0;
            pixel_index <= '0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            color_valid <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            unique case (state)
                SYNC: begin
                    if (reach_reset) begin
                        state <= LOW;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state <= HIGH;
                    end else if (reach_reset) begin
                        if (bit_cnt != 5'd0) err <= 1'b1;
                        if (pix_cnt != '0) frame_done <= 1'b1;
                        bit_cnt <= '0;
                        pix_cnt <= '0;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state <= LOW;
                        if (cnt < MIN_V) begin
                            err <= 1'b1;
                        end else if (bit_cnt == 5'd23) begin
                            sr          <= word;
                            color       <= word;
                            pixel_index <= pix_cnt;
                            color_valid <= 1'b1;
                            bit_cnt     <= '0;
                            if (pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
                        end else begin
                            sr      <= word;
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end else if (reach_max) begin
                        err     <= 1'b1;
                        bit_cnt <= '0;
                        pix_cnt <= '0;
                        state   <= SYNC;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_rx.sv
// Directed bench for ws2812b_rx: table of pixel frames plus
// hand-written latency, boundary, glitch, stuck-high and reset sequences.
module tb_ws2812b_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        din;
    logic [23:0] color;
    logic        color_valid;
    logic [15:0] pixel_index;
    logic        frame_done;
    logic        err;

    int checks = 0;
    int failures = 0;
    int n_cv = 0;
    int n_fd = 0;
    int n_err = 0;
    logic [23:0] last_color = '0;
    logic [15:0] last_idx = '0;

    ws2812b_rx dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .color(color),
        .color_valid(color_valid),
        .pixel_index(pixel_index),
        .frame_done(frame_done),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (color_valid) begin
            n_cv++;
            last_color = color;
            last_idx = pixel_index;
        end
        if (frame_done) n_fd++;
        if (err) n_err++;
    end

    typedef struct {
        logic [23:0] word;
        logic [15:0] idx;
        bit          latch;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input int hc);
        din = 1'b1;
        repeat (hc) @(negedge clk);
        din = 1'b0;
        repeat ((hc > 100) ? 45 : 125 - hc) @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] w, input int n);
        for (int b = 23; b > 23 - n; b--) send_bit(w[b] ? 80 : 40);
    endtask

    task automatic latch();
        din = 1'b0;
        repeat (5010) @(negedge clk);
    endtask

    int cv0, fd0, er0;
    logic [23:0] w;

    initial begin
        tbl[0] = '{24'h00FF00, 16'd0, 1'b1};
        tbl[1] = '{24'hFFFFFF, 16'd0, 1'b0};
        tbl[2] = '{24'h000000, 16'd1, 1'b1};
        tbl[3] = '{24'hA5C3E1, 16'd0, 1'b0};

        rst = 1'b0;
        din = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_color", color, 0);
        chk("rst_valid", color_valid, 0);
        chk("rst_index", pixel_index, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_err", err, 0);
        rst = 1'b1;
        latch();
        chk("sync_quiet", n_cv + n_fd + n_err, 0);

        for (int i = 0; i < 4; i++) begin
            cv0 = n_cv;
            fd0 = n_fd;
            send_bits(tbl[i].word, 24);
            repeat (5) @(negedge clk);
            chk("tbl_cv", n_cv - cv0, 1);
            chk("tbl_color", last_color, tbl[i].word);
            chk("tbl_index", last_idx, tbl[i].idx);
            if (tbl[i].latch) begin
                latch();
                chk("tbl_fd", n_fd - fd0, 1);
            end
        end
        chk("tbl_err", n_err, 0);

        // latency: strobe on 3rd rising edge after the final fall
        w = 24'h5A5A5B;
        send_bits(w, 23);
        din = 1'b1;
        repeat (80) @(negedge clk);
        din = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 chk("lat_edge2", color_valid, 0);
        @(posedge clk);
        #1 chk("lat_edge3", color_valid, 1);
        repeat (40) @(negedge clk);
        chk("lat_color", last_color, w);
        chk("lat_index", last_idx, 1);

        // width boundaries: 60->1, 59->0, 10->0, 199->1
        cv0 = n_cv;
        er0 = n_err;
        for (int i = 0; i < 6; i++) begin
            send_bit(60);
            send_bit(59);
        end
        for (int i = 0; i < 6; i++) begin
            send_bit(10);
            send_bit(199);
        end
        chk("bnd_cv", n_cv - cv0, 1);
        chk("bnd_color", last_color, 24'hAAA555);
        chk("bnd_index", last_idx, 2);
        chk("bnd_err", n_err - er0, 0);

        // 9-cycle glitch is dropped, word completes one bit later
        w = 24'hC0FFEE;
        cv0 = n_cv;
        send_bits(w, 10);
        send_bit(9);
        chk("gl_err", n_err - er0, 1);
        chk("gl_nocv", n_cv - cv0, 0);
        for (int b = 13; b >= 0; b--) send_bit(w[b] ? 80 : 40);
        chk("gl_cv", n_cv - cv0, 1);
        chk("gl_color", last_color, w);
        chk("gl_index", last_idx, 3);

        // partial word after pixels: err and frame_done together
        cv0 = n_cv;
        fd0 = n_fd;
        er0 = n_err;
        send_bits(24'hABCDEF, 12);
        latch();
        chk("pa_err", n_err - er0, 1);
        chk("pa_fd", n_fd - fd0, 1);
        // partial word with no pixels: err only
        send_bits(24'hABCDEF, 12);
        latch();
        chk("pb_err", n_err - er0, 2);
        chk("pb_fd", n_fd - fd0, 1);
        chk("pb_cv", n_cv - cv0, 0);
        send_bits(24'h123456, 24);
        chk("pb_color", last_color, 24'h123456);
        chk("pb_index", last_idx, 0);

        // stuck high for 300 cycles
        cv0 = n_cv;
        fd0 = n_fd;
        er0 = n_err;
        send_bits(24'hFFFFFF, 5);
        din = 1'b1;
        repeat (195) @(negedge clk);
        chk("st_early", n_err - er0, 0);
        repeat (20) @(negedge clk);
        chk("st_err", n_err - er0, 1);
        repeat (85) @(negedge clk);
        din = 1'b0;
        repeat (50) @(negedge clk);
        send_bits(24'hFFFFFF, 24);
        chk("st_ignored", n_cv - cv0, 0);
        latch();
        chk("st_fd", n_fd - fd0, 0);
        chk("st_err_once", n_err - er0, 1);
        send_bits(24'h0F0F0F, 24);
        chk("st_cv", n_cv - cv0, 1);
        chk("st_color", last_color, 24'h0F0F0F);
        chk("st_index", last_idx, 0);

        // reset mid-pixel, stream continues through release
        cv0 = n_cv;
        fd0 = n_fd;
        er0 = n_err;
        send_bits(24'hFFFFFF, 10);
        din = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("ar_color", color, 0);
        chk("ar_index", pixel_index, 0);
        chk("ar_strobes", {color_valid, frame_done, err}, 0);
        @(negedge clk);
        din = 1'b0;
        repeat (40) @(negedge clk);
        send_bits(24'hFFFFFF, 10);
        rst = 1'b1;
        send_bits(24'h00FFFF, 20);
        latch();
        chk("ar_cv", n_cv - cv0, 0);
        chk("ar_fd", n_fd - fd0, 0);
        chk("ar_err", n_err - er0, 0);
        send_bits(24'h3C3C3C, 24);
        chk("ar_cv2", n_cv - cv0, 1);
        chk("ar_color2", last_color, 24'h3C3C3C);
        chk("ar_index2", last_idx, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
